// File: rtl/reg_bank_writeback_pkg.sv
// Shared widths, error bit positions and register-code legality for the write-back register bank.
package reg_bank_writeback_pkg;

    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned CODE_W    = 8;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ERR_OOR   = 0;
    localparam int unsigned ERR_UNEXP = 1;

    // A code names real storage only if it is in range and is not the hardwired zero register.
    function automatic logic code_legal(input logic [CODE_W-1:0] code,
                                        input int unsigned        num_regs,
                                        input logic               zero_reg);
        return (32'(code) < num_regs) && !(zero_reg && (code == '0));
    endfunction

endpackage

// File: rtl/reg_bank_writeback_scoreboard.sv
// Pending-write scoreboard: tracks registers with an outstanding producer and refuses WAW reservations.
module reg_scoreboard
    import reg_bank_writeback_pkg::*;
#(
    parameter int unsigned NUM_REGS = reg_bank_writeback_pkg::NUM_REGS,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_legal,
    input  logic [CODE_W-1:0] wr_code,
    input  logic              issue_valid,
    input  logic [CODE_W-1:0] issue_code,
    input  logic [CODE_W-1:0] rd_a_code,
    input  logic [CODE_W-1:0] rd_b_code,
    output logic              issue_stall_c,
    output logic              rd_a_pending_c,
    output logic              rd_b_pending_c,
    output logic              wr_pending_c
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic                issue_legal;
    logic                issue_accept;

    // Indices are only trusted when the matching legality term is true.
    always_comb begin
        pending_nxt    = pending;
        issue_legal    = code_legal(issue_code, NUM_REGS, ZERO_REG);
        issue_stall_c  = issue_valid & issue_legal & pending[IDX_W'(issue_code)]
                         & ~(wr_legal & (wr_code == issue_code));
        issue_accept   = issue_valid & issue_legal & ~issue_stall_c;
        rd_a_pending_c = code_legal(rd_a_code, NUM_REGS, ZERO_REG) & pending[IDX_W'(rd_a_code)]
                         & ~(wr_legal & (wr_code == rd_a_code));
        rd_b_pending_c = code_legal(rd_b_code, NUM_REGS, ZERO_REG) & pending[IDX_W'(rd_b_code)]
                         & ~(wr_legal & (wr_code == rd_b_code));
        wr_pending_c   = pending[IDX_W'(wr_code)];
        if (wr_legal) begin
            pending_nxt[IDX_W'(wr_code)] = 1'b0;
        end
        // A new reservation applied after the clear so the new producer wins.
        if (issue_accept) begin
            pending_nxt[IDX_W'(issue_code)] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

endmodule

// File: rtl/reg_bank_writeback.sv
// Architectural register bank fed by the write-back mux, with bypassed read ports and hazard scoreboard.
module reg_bank_writeback
    import reg_bank_writeback_pkg::*;
#(
    parameter int unsigned NUM_REGS = reg_bank_writeback_pkg::NUM_REGS,
    parameter bit          ZERO_REG = 1'b1,
    parameter int unsigned DATA_W   = reg_bank_writeback_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              REG_write_back_flag,
    input  logic [7:0]        REG_write_back_code,
    input  logic [DATA_W-1:0] REG_write_back_data,
    input  logic [7:0]        rd_a_code,
    output logic [DATA_W-1:0] rd_a_data,
    output logic              rd_a_pending,
    input  logic [7:0]        rd_b_code,
    output logic [DATA_W-1:0] rd_b_data,
    output logic              rd_b_pending,
    input  logic              issue_valid,
    input  logic [7:0]        issue_code,
    output logic              issue_stall,
    input  logic              err_clr,
    output logic [1:0]        wb_err,
    output logic [15:0]       wb_count
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_legal_c;
    logic              wr_oor_c;
    logic              wr_unexp_c;
    logic              wr_pending_c;
    logic [1:0]        err_evt_c;

    always_comb begin
        wr_legal_c = REG_write_back_flag & code_legal(REG_write_back_code, NUM_REGS, ZERO_REG);
        wr_oor_c   = REG_write_back_flag & (32'(REG_write_back_code) >= NUM_REGS);
        wr_unexp_c = wr_legal_c & ~wr_pending_c;
        err_evt_c            = '0;
        err_evt_c[ERR_OOR]   = wr_oor_c;
        err_evt_c[ERR_UNEXP] = wr_unexp_c;
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .wr_legal       (wr_legal_c),
        .wr_code        (REG_write_back_code),
        .issue_valid    (issue_valid),
        .issue_code     (issue_code),
        .rd_a_code      (rd_a_code),
        .rd_b_code      (rd_b_code),
        .issue_stall_c  (issue_stall),
        .rd_a_pending_c (rd_a_pending),
        .rd_b_pending_c (rd_b_pending),
        .wr_pending_c   (wr_pending_c)
    );

    // Illegal codes (out of range or zero register) read as 0; a same-cycle commit bypasses storage.
    always_comb begin
        rd_a_data = '0;
        rd_b_data = '0;
        if (code_legal(rd_a_code, NUM_REGS, ZERO_REG)) begin
            rd_a_data = (wr_legal_c && (REG_write_back_code == rd_a_code))
                        ? REG_write_back_data : regs[IDX_W'(rd_a_code)];
        end
        if (code_legal(rd_b_code, NUM_REGS, ZERO_REG)) begin
            rd_b_data = (wr_legal_c && (REG_write_back_code == rd_b_code))
                        ? REG_write_back_data : regs[IDX_W'(rd_b_code)];
        end
    end

    // Error bits are sticky; a same-cycle event beats err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
            wb_err   <= '0;
            wb_count <= '0;
        end else begin
            if (wr_legal_c) begin
                regs[IDX_W'(REG_write_back_code)] <= REG_write_back_data;
                wb_count                          <= wb_count + 16'd1;
            end
            wb_err <= (err_clr ? 2'b00 : wb_err) | err_evt_c;
        end
    end

endmodule

// File: tb/tb_reg_bank_writeback.sv
// Self-checking bench: behavioural reference model plus a commit queue read back through port B.
module tb_reg_bank_writeback;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        REG_write_back_flag = 1'b0;
    logic [7:0]  REG_write_back_code = '0;
    logic [31:0] REG_write_back_data = '0;
    logic [7:0]  rd_a_code = '0;
    logic [31:0] rd_a_data;
    logic        rd_a_pending;
    logic [7:0]  rd_b_code = '0;
    logic [31:0] rd_b_data;
    logic        rd_b_pending;
    logic        issue_valid = 1'b0;
    logic [7:0]  issue_code = '0;
    logic        issue_stall;
    logic        err_clr = 1'b0;
    logic [1:0]  wb_err;
    logic [15:0] wb_count;

    reg_bank_writeback dut (
        .clk                 (clk),
        .rst                 (rst),
        .REG_write_back_flag (REG_write_back_flag),
        .REG_write_back_code (REG_write_back_code),
        .REG_write_back_data (REG_write_back_data),
        .rd_a_code           (rd_a_code),
        .rd_a_data           (rd_a_data),
        .rd_a_pending        (rd_a_pending),
        .rd_b_code           (rd_b_code),
        .rd_b_data           (rd_b_data),
        .rd_b_pending        (rd_b_pending),
        .issue_valid         (issue_valid),
        .issue_code          (issue_code),
        .issue_stall         (issue_stall),
        .err_clr             (err_clr),
        .wb_err              (wb_err),
        .wb_count            (wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        logic [31:0] data;
    } wb_item_t;

    wb_item_t    sb_q[$];
    logic [31:0] m_regs [32];
    bit          m_pend [32];
    logic [1:0]  m_err;
    logic [15:0] m_cnt;
    bit          quiet;
    int          n_chk;
    int          n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic bit m_legal(input logic [7:0] c);
        return (c < 8'd32) && (c != 8'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] c, input bit wl,
                                           input logic [7:0] wc, input logic [31:0] wd);
        if (!m_legal(c)) return 32'h0;
        if (wl && (wc == c)) return wd;
        return m_regs[c[4:0]];
    endfunction

    function automatic bit m_pend_at(input logic [7:0] c, input bit wl, input logic [7:0] wc);
        return m_legal(c) && m_pend[c[4:0]] && !(wl && (wc == c));
    endfunction

    // One clock: drive, check combinational outputs mid-cycle, update model at the edge, check state after.
    task automatic cycle(input bit flag, input logic [7:0] wc, input logic [31:0] wd,
                         input bit iv, input logic [7:0] ic, input bit clr,
                         input bit rst_v, input logic [7:0] rda);
        bit       wl, oor, unexp, stall, acc;
        wb_item_t it;
        REG_write_back_flag = flag;
        REG_write_back_code = wc;
        REG_write_back_data = wd;
        issue_valid         = iv;
        issue_code          = ic;
        err_clr             = clr;
        rst                 = rst_v;
        rd_a_code           = rda;
        wl    = flag && m_legal(wc);
        oor   = flag && (wc >= 8'd32);
        stall = iv && m_legal(ic) && m_pend[ic[4:0]] && !(wl && (wc == ic));
        acc   = iv && m_legal(ic) && !stall;
        @(negedge clk);
        if (!quiet) begin
            check("rd_a_data", rd_a_data, m_read(rda, wl, wc, wd));
            check("rd_a_pending", 32'(rd_a_pending), 32'(m_pend_at(rda, wl, wc)));
            check("issue_stall", 32'(issue_stall), 32'(stall));
        end
        @(posedge clk);
        if (rst_v) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
            m_err = '0;
            m_cnt = '0;
        end else begin
            unexp = wl && !m_pend[wc[4:0]];
            if (wl) begin
                m_regs[wc[4:0]] = wd;
                m_pend[wc[4:0]] = 1'b0;
                m_cnt           = m_cnt + 16'd1;
                if (!quiet) sb_q.push_back('{code: wc, data: wd});
            end
            if (acc) m_pend[ic[4:0]] = 1'b1;
            if (clr) m_err = '0;
            m_err = m_err | {unexp, oor};
        end
        #1;
        REG_write_back_flag = 1'b0;
        issue_valid         = 1'b0;
        err_clr             = 1'b0;
        rst                 = 1'b0;
        if (!quiet) begin
            check("wb_err", 32'(wb_err), 32'(m_err));
            check("wb_count", 32'(wb_count), 32'(m_cnt));
            while (sb_q.size() > 0) begin
                it        = sb_q.pop_front();
                rd_b_code = it.code;
                #1;
                check("stored", rd_b_data, it.data);
                check("rd_b_pending", 32'(rd_b_pending), 32'(m_pend[it.code[4:0]]));
            end
        end
    endtask

    task automatic idle(input logic [7:0] rda);
        cycle(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 1'b0, 1'b0, rda);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        m_err  = '0;
        m_cnt  = '0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end

        // Reset from unknown state, then sweep every register.
        quiet = 1'b1;
        cycle(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0);
        quiet = 1'b0;
        check("rst_err", 32'(wb_err), 32'h0);
        check("rst_count", 32'(wb_count), 32'h0);
        for (int c = 0; c < 32; c++) idle(8'(c));

        // Issue then commit with bypass.
        cycle(1'b0, 8'd0, 32'h0, 1'b1, 8'd5, 1'b0, 1'b0, 8'd5);
        idle(8'd5);
        check("pend5_before", 32'(rd_a_pending), 32'h1);
        cycle(1'b1, 8'd5, 32'hDEADBEEF, 1'b0, 8'd0, 1'b0, 1'b0, 8'd5);
        check("count_after5", 32'(wb_count), 32'h1);
        idle(8'd5);
        check("store5", rd_a_data, 32'hDEADBEEF);

        // WAW stall, then write and reissue in the same cycle.
        cycle(1'b0, 8'd0, 32'h0, 1'b1, 8'd7, 1'b0, 1'b0, 8'd7);
        cycle(1'b0, 8'd0, 32'h0, 1'b1, 8'd7, 1'b0, 1'b0, 8'd7);
        idle(8'd7);
        cycle(1'b1, 8'd7, 32'hA5A5_0007, 1'b1, 8'd7, 1'b0, 1'b0, 8'd7);
        idle(8'd7);
        check("pend7_kept", 32'(rd_a_pending), 32'h1);

        // Zero register and out-of-range writes, then clear.
        cycle(1'b1, 8'd0, 32'h1234, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0);
        check("zero_noerr", 32'(wb_err), 32'h0);
        cycle(1'b1, 8'd40, 32'h55, 1'b0, 8'd0, 1'b0, 1'b0, 8'd40);
        check("oor_err", 32'(wb_err), 32'h1);
        cycle(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 1'b1, 1'b0, 8'd0);
        check("err_clr", 32'(wb_err), 32'h0);

        // Unexpected write, then err_clr racing a new event.
        cycle(1'b1, 8'd3, 32'h0000_0333, 1'b0, 8'd0, 1'b0, 1'b0, 8'd3);
        check("unexp_err", 32'(wb_err), 32'h2);
        cycle(1'b1, 8'd50, 32'h1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd3);
        check("set_wins", 32'(wb_err), 32'h1);

        // Reset beats a same-cycle write.
        cycle(1'b1, 8'd9, 32'hCAFE_F00D, 1'b1, 8'd9, 1'b0, 1'b1, 8'd9);
        idle(8'd9);
        check("rst_drop", rd_a_data, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 2) != 0), 8'($urandom_range(0, 47)), $urandom,
                  ($urandom_range(0, 1) != 0), 8'($urandom_range(0, 47)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0),
                  8'($urandom_range(0, 47)));
        end

        // Counter wrap.
        cycle(1'b0, 8'd0, 32'h0, 1'b0, 8'd0, 1'b0, 1'b1, 8'd0);
        quiet = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            cycle(1'b1, 8'(1 + (i % 31)), 32'(i), 1'b0, 8'd0, 1'b0, 1'b0, 8'd1);
        end
        quiet = 1'b0;
        check("count_ffff", 32'(wb_count), 32'h0000_FFFF);
        cycle(1'b1, 8'd2, 32'h0BAD_BEEF, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2);
        check("count_wrap", 32'(wb_count), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
